// File: rtl/dmem_pkg.sv
// Shared definitions for the dmem_port data-memory slice: size encodings,
// FSM state type and the per-byte parity helper.
package dmem_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } state_t;

   // Even parity: the stored bit makes each byte-plus-parity group even.
   function automatic logic [3:0] byte_parity(input logic [31:0] w);
      logic [3:0] p;
      for (int i = 0; i < 4; i++) begin
         p[i] = ^w[8*i +: 8];
      end
      return p;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store replication/byte enables and load
// extract with sign or zero extension.
module dmem_lane_align
   import dmem_pkg::*;
(
   input  logic [1:0]  size,
   input  logic [1:0]  off,
   input  logic        unsigned_ld,
   input  logic [31:0] wd,
   input  logic [31:0] rword,
   output logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] ld_data
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Steer store data onto lanes and pull the addressed lanes out of a load.
   always_comb begin
      wdata   = 32'd0;
      be      = 4'b0000;
      ld_data = 32'd0;
      byte_s  = rword[{off, 3'b000} +: 8];
      half_s  = off[1] ? rword[31:16] : rword[15:0];
      case (size)
         SZ_BYTE: begin
            wdata   = {4{wd[7:0]}};
            be      = 4'b0001 << off;
            ld_data = unsigned_ld ? {24'd0, byte_s} : {{24{byte_s[7]}}, byte_s};
         end
         SZ_HALF: begin
            wdata   = {2{wd[15:0]}};
            be      = off[1] ? 4'b1100 : 4'b0011;
            ld_data = unsigned_ld ? {16'd0, half_s} : {{16{half_s[15]}}, half_s};
         end
         SZ_WORD: begin
            wdata   = wd;
            be      = 4'b1111;
            ld_data = rword;
         end
         default: begin
            wdata   = 32'd0;
            be      = 4'b0000;
            ld_data = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_port.sv
// Fixed-latency 32-bit data memory port with byte/half/word access.
// Optional per-byte parity and parity_err output when DMEM_PARITY_EN is defined.
module dmem_port
   import dmem_pkg::*;
#(
   parameter int ADDR_W  = 6,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        we,
   input  logic [31:0] a,
   input  logic [31:0] wd,
   input  logic [1:0]  size,
   input  logic        unsigned_ld,
   output logic        resp_valid,
   output logic [31:0] rd,
   output logic        misalign,
   output logic        out_of_range
`ifdef DMEM_PARITY_EN
  ,output logic        parity_err
`endif
);

   localparam int         DEPTH     = 2 ** ADDR_W;
   localparam logic [1:0] BUSY_LAST = 2'(LATENCY - 2);

   state_t      state_r, state_next_s;
   logic [1:0]  cnt_r, cnt_next_s;

   logic        we_r, uns_r;
   logic [31:0] a_r, wd_r;
   logic [1:0]  size_r;

   logic        cur_we_s, cur_uns_s;
   logic [31:0] cur_a_s, cur_wd_s;
   logic [1:0]  cur_size_s;

   logic        accept_s, enter_resp_s, wr_en_s;
   logic        misalign_s, oor_s, ok_s;
   logic [ADDR_W-1:0] idx_s;
   logic [31:0] rword_s, wdata_s, ld_data_s;
   logic [3:0]  be_s;

   logic        ready_r, resp_valid_r, misalign_r, oor_r;
   logic [31:0] rd_r;

   logic [31:0] mem_r [DEPTH];

   assign accept_s = req_valid && (state_r == IDLE);

   // With LATENCY=1 the RAM is accessed on the accept edge, before capture.
   always_comb begin
      if (state_r == IDLE) begin
         cur_we_s   = we;
         cur_a_s    = a;
         cur_wd_s   = wd;
         cur_size_s = size;
         cur_uns_s  = unsigned_ld;
      end else begin
         cur_we_s   = we_r;
         cur_a_s    = a_r;
         cur_wd_s   = wd_r;
         cur_size_s = size_r;
         cur_uns_s  = uns_r;
      end
   end

   // Alignment and range classification of the current request.
   always_comb begin
      misalign_s = 1'b0;
      case (cur_size_s)
         SZ_BYTE: misalign_s = 1'b0;
         SZ_HALF: misalign_s = cur_a_s[0];
         SZ_WORD: misalign_s = |cur_a_s[1:0];
         default: misalign_s = 1'b1;
      endcase
      oor_s = (cur_a_s >> (ADDR_W + 2)) != 32'd0;
      ok_s  = !misalign_s && !oor_s;
      idx_s = cur_a_s[ADDR_W+1:2];
   end

   assign rword_s = mem_r[idx_s];

   dmem_lane_align u_align (
      .size        (cur_size_s),
      .off         (cur_a_s[1:0]),
      .unsigned_ld (cur_uns_s),
      .wd          (cur_wd_s),
      .rword       (rword_s),
      .wdata       (wdata_s),
      .be          (be_s),
      .ld_data     (ld_data_s)
   );

   // Next-state logic: BUSY waits LATENCY-1 cycles, RESP lasts one cycle.
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (LATENCY > 1) begin
                  state_next_s = BUSY;
                  cnt_next_s   = 2'd0;
               end else begin
                  state_next_s = RESP;
                  cnt_next_s   = 2'd0;
               end
            end else begin
               state_next_s = IDLE;
            end
         end
         BUSY: begin
            if (cnt_r == BUSY_LAST) begin
               state_next_s = RESP;
               cnt_next_s   = 2'd0;
            end else begin
               cnt_next_s   = cnt_r + 2'd1;
            end
         end
         RESP:    state_next_s = IDLE;
         default: state_next_s = IDLE;
      endcase
   end

   assign enter_resp_s = (state_next_s == RESP) && (state_r != RESP);
   assign wr_en_s      = enter_resp_s && cur_we_s && ok_s && !reset;

`ifdef DMEM_PARITY_EN
   logic [3:0] par_r [DEPTH];
   logic       perr_s, perr_r;

   assign perr_s = !cur_we_s && ok_s && |(be_s & (byte_parity(rword_s) ^ par_r[idx_s]));

   // Parity bits follow every lane write; like the data, never reset.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en_s && be_s[i]) begin
            par_r[idx_s][i] <= ^wdata_s[8*i +: 8];
         end
      end
   end

   // Parity error flag, only meaningful alongside resp_valid.
   always_ff @(posedge clk) begin
      if (reset) begin
         perr_r <= 1'b0;
      end else begin
         perr_r <= enter_resp_s ? perr_s : 1'b0;
      end
   end

   assign parity_err = perr_r;
`endif

   // RAM contents deliberately survive reset; a reset edge suppresses the write.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (wr_en_s && be_s[i]) begin
            mem_r[idx_s][8*i +: 8] <= wdata_s[8*i +: 8];
         end
      end
   end

   // FSM state, request capture and registered response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= IDLE;
         cnt_r        <= 2'd0;
         ready_r      <= 1'b1;
         resp_valid_r <= 1'b0;
         rd_r         <= 32'd0;
         misalign_r   <= 1'b0;
         oor_r        <= 1'b0;
         we_r         <= 1'b0;
         a_r          <= 32'd0;
         wd_r         <= 32'd0;
         size_r       <= 2'b00;
         uns_r        <= 1'b0;
      end else begin
         state_r      <= state_next_s;
         cnt_r        <= cnt_next_s;
         ready_r      <= (state_next_s == IDLE);
         resp_valid_r <= enter_resp_s;
         if (enter_resp_s) begin
            misalign_r <= misalign_s;
            oor_r      <= oor_s;
            rd_r       <= (!cur_we_s && ok_s) ? ld_data_s : 32'd0;
         end else begin
            misalign_r <= 1'b0;
            oor_r      <= 1'b0;
            rd_r       <= 32'd0;
         end
         if (accept_s) begin
            we_r   <= we;
            a_r    <= a;
            wd_r   <= wd;
            size_r <= size;
            uns_r  <= unsigned_ld;
         end
      end
   end

   assign req_ready    = ready_r;
   assign resp_valid   = resp_valid_r;
   assign rd           = rd_r;
   assign misalign     = misalign_r;
   assign out_of_range = oor_r;

endmodule

// File: tb/tb_dmem_port.sv
// Scoreboard bench for dmem_port: LATENCY=1 and LATENCY=3 instances against a
// byte-level memory model. Parity injection runs only with DMEM_PARITY_EN.
module tb_dmem_port;

   typedef struct {
      logic [31:0] rd;
      logic        mis;
      logic        oor;
      logic        pe;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rv1 = 1'b0, rv3 = 1'b0;
   logic        we = 1'b0, unsigned_ld = 1'b0;
   logic [31:0] a = 32'd0, wd = 32'd0;
   logic [1:0]  size = 2'b00;
   logic        req_ready1, req_ready3, resp_valid1, resp_valid3;
   logic [31:0] rd1, rd3;
   logic        mis1, mis3, oor1, oor3, pe1, pe3;

   exp_t        q1[$], q3[$];
   logic [31:0] mdl [2][64];
   int          cyc = 0;
   int          n_cmp = 0, n_err = 0;
   logic        mon_en = 1'b0;
   logic        exp_pe_next = 1'b0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_port #(.ADDR_W(6), .LATENCY(1)) dut1 (
      .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(req_ready1),
      .we(we), .a(a), .wd(wd), .size(size), .unsigned_ld(unsigned_ld),
      .resp_valid(resp_valid1), .rd(rd1), .misalign(mis1), .out_of_range(oor1)
`ifdef DMEM_PARITY_EN
     ,.parity_err(pe1)
`endif
   );

   dmem_port #(.ADDR_W(6), .LATENCY(3)) dut3 (
      .clk(clk), .reset(reset), .req_valid(rv3), .req_ready(req_ready3),
      .we(we), .a(a), .wd(wd), .size(size), .unsigned_ld(unsigned_ld),
      .resp_valid(resp_valid3), .rd(rd3), .misalign(mis3), .out_of_range(oor3)
`ifdef DMEM_PARITY_EN
     ,.parity_err(pe3)
`endif
   );

`ifndef DMEM_PARITY_EN
   assign pe1 = 1'b0;
   assign pe3 = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   // Reference behaviour, built byte by byte from the access size.
   function automatic exp_t model(input int k, input logic w, input logic [31:0] addr,
                                  input logic [31:0] dat, input logic [1:0] sz, input logic u);
      exp_t        e;
      int          nb, lane, wi;
      logic [31:0] v;
      e.mis = (sz == 2'b11) || (sz == 2'b01 && addr[0]) || (sz == 2'b10 && addr[1:0] != 2'b00);
      e.oor = addr[31:2] >= 30'd64;
      e.rd  = 32'd0;
      e.pe  = 1'b0;
      e.due = 0;
      if (!e.mis && !e.oor) begin
         nb   = 1 << sz;
         lane = int'(addr[1:0]);
         wi   = int'(addr[7:2]);
         if (w) begin
            for (int b = 0; b < nb; b++) mdl[k][wi][8*(lane+b) +: 8] = dat[8*b +: 8];
         end else begin
            v = 32'd0;
            for (int b = 0; b < nb; b++) v[8*b +: 8] = mdl[k][wi][8*(lane+b) +: 8];
            if (nb == 4 || u) e.rd = v;
            else if (nb == 1) e.rd = {{24{v[7]}}, v[7:0]};
            else e.rd = {{16{v[15]}}, v[15:0]};
         end
      end
      return e;
   endfunction

   task automatic mon(input int k, input logic v, input logic [31:0] r, input logic m,
                      input logic o, input logic p);
      exp_t e;
      int   qs;
      qs = (k == 0) ? q1.size() : q3.size();
      if (v) begin
         if (qs == 0) begin
            check(k == 0 ? "unexpected_resp_l1" : "unexpected_resp_l3", 32'(qs), 32'd1);
         end else begin
            if (k == 0) e = q1.pop_front(); else e = q3.pop_front();
            check("resp_cycle", 32'(cyc), 32'(e.due));
            check("rd", r, e.rd);
            check("misalign", {31'd0, m}, {31'd0, e.mis});
            check("out_of_range", {31'd0, o}, {31'd0, e.oor});
            check("parity_err", {31'd0, p}, {31'd0, e.pe});
         end
      end else begin
         check("hold_zero", r | {29'd0, m, o, p}, 32'd0);
         if (qs != 0) begin
            e = (k == 0) ? q1[0] : q3[0];
            if (cyc > e.due) begin
               check("resp_missing", 32'(cyc), 32'(e.due));
               if (k == 0) void'(q1.pop_front()); else void'(q3.pop_front());
            end
         end
      end
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         mon(0, resp_valid1, rd1, mis1, oor1, pe1);
         mon(1, resp_valid3, rd3, mis3, oor3, pe3);
      end
   end

   task automatic issue(input int k, input logic w, input logic [31:0] addr,
                        input logic [31:0] dat, input logic [1:0] sz, input logic u);
      exp_t e;
      int   n;
      n = 0;
      @(negedge clk);
      while (((k == 0) ? req_ready1 : req_ready3) !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) check("ready_timeout", 32'(n), 32'd0);
      we = w; a = addr; wd = dat; size = sz; unsigned_ld = u;
      e = model(k, w, addr, dat, sz, u);
      e.due = cyc + ((k == 0) ? 1 : 3);
      e.pe  = exp_pe_next;
      exp_pe_next = 1'b0;
      if (k == 0) begin q1.push_back(e); rv1 = 1'b1; end
      else begin q3.push_back(e); rv3 = 1'b1; end
      @(posedge clk);
      #1;
      rv1 = 1'b0;
      rv3 = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((q1.size() + q3.size()) != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) check("drain_timeout", 32'(q1.size() + q3.size()), 32'd0);
      @(negedge clk);
   endtask

   task automatic fill_and_random(input int k);
      for (int w = 0; w < 64; w++) issue(k, 1'b1, 32'(w * 4), $urandom, 2'b10, 1'b0);
      for (int i = 0; i < 30; i++) begin
         issue(k, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h10F)), $urandom,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      end
      drain();
   endtask

   initial begin
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset_ready1", {31'd0, req_ready1}, 32'd1);
      check("reset_ready3", {31'd0, req_ready3}, 32'd1);
      check("reset_resp", {30'd0, resp_valid1, resp_valid3}, 32'd0);
      check("reset_rd", rd1 | rd3, 32'd0);
      check("reset_flags", {28'd0, mis1, mis3, oor1, oor3}, 32'd0);
      reset = 1'b0;
      mon_en = 1'b1;

      // LATENCY=1 directed sequence.
      fill_and_random(0);
      issue(0, 1'b1, 32'h10, 32'hDEADBEEF, 2'b10, 1'b0);
      issue(0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0);
      issue(0, 1'b1, 32'h13, 32'h00000080, 2'b00, 1'b0);
      issue(0, 1'b0, 32'h13, 32'd0, 2'b00, 1'b0);
      issue(0, 1'b0, 32'h13, 32'd0, 2'b00, 1'b1);
      issue(0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0);
      issue(0, 1'b0, 32'h11, 32'd0, 2'b01, 1'b0);
      issue(0, 1'b0, 32'h10, 32'd0, 2'b10, 1'b0);
      issue(0, 1'b1, 32'h00, 32'h12345678, 2'b10, 1'b0);
      issue(0, 1'b1, 32'h100, 32'hFFFFFFFF, 2'b10, 1'b0);
      issue(0, 1'b0, 32'h00, 32'd0, 2'b10, 1'b0);
      issue(0, 1'b0, 32'h101, 32'd0, 2'b10, 1'b0);
      issue(0, 1'b0, 32'h20, 32'd0, 2'b11, 1'b0);
      issue(0, 1'b1, 32'h16, 32'h00008001, 2'b01, 1'b0);
      issue(0, 1'b0, 32'h16, 32'd0, 2'b01, 1'b0);
      issue(0, 1'b0, 32'h16, 32'd0, 2'b01, 1'b1);
      drain();

      // LATENCY=3: busy window and held req_valid.
      fill_and_random(1);
      @(negedge clk);
      check("ready_before", {31'd0, req_ready3}, 32'd1);
      we = 1'b1; a = 32'h20; wd = 32'h11111111; size = 2'b10; unsigned_ld = 1'b0;
      begin
         exp_t e;
         e = model(1, 1'b1, 32'h20, 32'h11111111, 2'b10, 1'b0);
         e.due = cyc + 3;
         q3.push_back(e);
      end
      rv3 = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         @(negedge clk);
         check("ready_busy", {31'd0, req_ready3}, 32'd0);
         a = 32'h24; wd = 32'hBAD0BAD0;
      end
      @(negedge clk);
      check("ready_after", {31'd0, req_ready3}, 32'd1);
      rv3 = 1'b0;
      issue(1, 1'b0, 32'h24, 32'd0, 2'b10, 1'b0);
      issue(1, 1'b0, 32'h20, 32'd0, 2'b10, 1'b0);
      drain();

      // LATENCY=3: reset during BUSY aborts the store.
      @(negedge clk);
      we = 1'b1; a = 32'h28; wd = 32'hCAFEF00D; size = 2'b10;
      rv3 = 1'b1;
      @(posedge clk);
      #1;
      rv3 = 1'b0;
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      check("abort_ready", {31'd0, req_ready3}, 32'd1);
      check("abort_resp", {31'd0, resp_valid3}, 32'd0);
      repeat (4) @(negedge clk);
      issue(1, 1'b0, 32'h28, 32'd0, 2'b10, 1'b0);
      drain();

`ifdef DMEM_PARITY_EN
      issue(1, 1'b1, 32'h2C, 32'h0F0F0F0F, 2'b10, 1'b0);
      drain();
      dut3.mem_r[11] = dut3.mem_r[11] ^ 32'd1;
      mdl[1][11] = mdl[1][11] ^ 32'd1;
      exp_pe_next = 1'b1;
      issue(1, 1'b0, 32'h2C, 32'd0, 2'b10, 1'b0);
      issue(1, 1'b0, 32'h2E, 32'd0, 2'b01, 1'b0);
      drain();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete, compared %0d", n_cmp);
      $fatal(1);
   end

endmodule

// File: doc/dmem_port.md
DMEM_PORT -- requirements
Module: dmem_port

Interface
REQ-001 Parameter ADDR_W, default 6, word-address bits (depth 2**ADDR_W words of 32 bits).
REQ-002 Parameter LATENCY, default 1, legal 1..4, cycles from request accept to response.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 we  input  1  1 = store, 0 = load.
REQ-008 a  input  32  byte address.
REQ-009 wd  input  32  store data, right-justified.
REQ-010 size  input  2  00 byte, 01 half, 10 word; 11 illegal.
REQ-011 unsigned_ld  input  1  1 = zero-extend loads, 0 = sign-extend.
REQ-012 resp_valid  output  1  one-cycle pulse, response valid.
REQ-013 rd  output  32  load data, extended; 0 for stores and errors.
REQ-014 misalign  output  1  valid with resp_valid; half not 2-aligned, word not 4-aligned, or size 11.
REQ-015 out_of_range  output  1  valid with resp_valid; a[31:2] >= 2**ADDR_W.

Function
REQ-016 The FSM SHALL have states IDLE, BUSY, RESP; req_ready = 1 only in IDLE.
REQ-017 Accept occurs when req_valid && req_ready; we, a, wd, size, unsigned_ld are captured on the accepting edge.
REQ-018 IDLE->BUSY on accept when LATENCY>1; IDLE->RESP on accept when LATENCY=1; BUSY counts LATENCY-1 cycles, then goes to RESP; RESP->IDLE unconditionally.
REQ-019 Accept in cycle N SHALL produce resp_valid high in exactly cycle N+LATENCY for one cycle; the next accept is possible in cycle N+LATENCY+1.
REQ-020 The RAM access SHALL occur on the edge entering RESP; stores update only the byte lanes selected by size and a[1:0].
REQ-021 Byte lane = a[1:0]; half lanes = a[1] ? [31:16] : [15:0]; word writes all four lanes.
REQ-022 Loads SHALL extract the addressed lane(s) and extend to 32 bits per unsigned_ld; word loads ignore unsigned_ld.
REQ-023 Misaligned or out-of-range requests SHALL NOT modify RAM, SHALL return rd = 0, and SHALL still respond after LATENCY; both flags may be set together.
REQ-024 req_valid while not in IDLE SHALL be ignored (no capture, no side effect).
REQ-025 rd, misalign and out_of_range SHALL be held at 0 whenever resp_valid is 0.

Reset
REQ-026 reset SHALL force IDLE, counter 0, resp_valid 0, rd 0, misalign 0, out_of_range 0, req_ready 1 on the next edge.
REQ-027 reset during BUSY SHALL abort the request: no RAM write and no response.
REQ-028 RAM contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With DMEM_PARITY_EN defined, one even-parity bit per byte is stored on every lane write, an output parity_err (1 bit) exists, and it is set with resp_valid when any byte read by a load fails parity; rd is still returned.
REQ-030 Without DMEM_PARITY_EN, no parity storage and no parity_err port exist.

Structure
REQ-031 A shared package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-032 One sub-module, dmem_lane_align, SHALL do the combinational store lane steering/byte-enable generation and the load extract/extend.

Verification
REQ-033 LATENCY=1: store word 0xDEADBEEF @0x10, load word @0x10 -> resp_valid 1 cycle after each accept, rd=0xDEADBEEF.
REQ-034 Store byte 0x80 @0x13, signed load byte @0x13 -> rd=0xFFFFFF80; unsigned -> 0x00000080; load word @0x10 -> 0x80ADBEEF.
REQ-035 Load half @0x11 -> misalign=1, rd=0; then load word @0x10 -> data unchanged.
REQ-036 ADDR_W=6: store @0x100 -> out_of_range=1; RAM word 0 unchanged.
REQ-037 LATENCY=3: accept at cycle 5 -> req_ready low cycles 6-8, resp_valid cycle 8; req_valid held during busy causes no extra accept.
REQ-038 LATENCY=3: store accepted, reset asserted next cycle -> no resp_valid, subsequent load returns old data; with DMEM_PARITY_EN, a forced flipped bit gives parity_err=1.
